// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-step shift-add multiply / restoring divide for the HI/LO path.
// Stalls the core while HI/LO are pending and strobes the 64-bit result into HI/LO.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV with a FIX sign-correction state).
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             we_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // acc holds {hi, lo} of the product, or {remainder, quotient} while dividing
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // multiplicand for MULT, divisor for DIV
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               fix_q, fix_d;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
  localparam logic [WIDTH-1:0]   One  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] One2 = (2*WIDTH)'(1);
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;
  logic a_neg, b_neg, div_zero;

  // Operand magnitudes on accept; a zero divisor keeps the raw dividend so hi = a
  always_comb begin
    a_neg    = op_signed & a[WIDTH-1];
    b_neg    = op_signed & b[WIDTH-1];
    div_zero = op_div & (b == '0);
    a_mag    = (a_neg && !div_zero) ? (~a + One) : a;
    b_mag    = b_neg ? (~b + One) : b;
  end
`else
  logic unused_signed;
  assign unused_signed = op_signed;

  // Unsigned-only build: operands pass straight through
  always_comb begin
    a_mag = a;
    b_mag = b;
  end
`endif

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      fix_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      fix_q   <= fix_d;
      // HI/LO only change on the edge entering DONE
      if (state_d == StDone) begin
        hi_q <= acc_d[2*WIDTH-1:WIDTH];
        lo_q <= acc_d[WIDTH-1:0];
      end
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == '0) state_d = fix_q ? StFix : StDone;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Iteration datapath: operand latch, shift-add / trial-subtract step, sign fix
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    fix_d    = fix_q;
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = CntLast;
          div_d = op_div;
          if (op_div) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
`ifdef MULDIV_SIGNED_EN
          fix_d     = op_signed & ~div_zero;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
`else
          fix_d = 1'b0;
`endif
        end
      end
      StRun: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (div_q) begin
          if (!div_diff[WIDTH+1]) begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
      end
`ifdef MULDIV_SIGNED_EN
      StFix: begin
        if (!div_q) begin
          if (neg_res_q) acc_d = ~acc_q + One2;
        end else begin
          if (neg_res_q) acc_d[WIDTH-1:0] = ~acc_q[WIDTH-1:0] + One;
          if (neg_rem_q) acc_d[2*WIDTH-1:WIDTH] = ~acc_q[2*WIDTH-1:WIDTH] + One;
        end
      end
`endif
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    we_hilo = done;
    stall   = busy & (mf_req | start);
    hi      = hi_q;
    lo      = lo_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (unsigned or MULDIV_SIGNED_EN build).
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, op_div, op_signed, mf_req;
  logic [31:0] a, b;
  logic        busy, stall, done, we_hilo;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_div    (op_div),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .mf_req    (mf_req),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .we_hilo   (we_hilo),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency, result and the single-cycle strobe
  task automatic run_op(input string tag, input logic div, input logic sgn,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat);
    int cyc;
    start = 1'b1; op_div = div; op_signed = sgn; a = ia; b = ib;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " hi"}, {32'h0, hi}, {32'h0, exp_hi});
    check({tag, " lo"}, {32'h0, lo}, {32'h0, exp_lo});
    check({tag, " we_hilo"}, {63'h0, we_hilo}, 64'h1);
    tick();
    check({tag, " we_hilo drop"}, {63'h0, we_hilo}, 64'h0);
    check({tag, " busy drop"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    int  lat;

`ifdef MULDIV_SIGNED_EN
    lat = 34;
`else
    lat = 33;
`endif
    rst = 1'b1; start = 1'b0; op_div = 1'b0; op_signed = 1'b0; mf_req = 1'b0;
    a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    check("reset we_hilo", {63'h0, we_hilo}, 64'h0);
    check("reset hi/lo", {hi, lo}, 64'h0);
    start = 1'b1; mf_req = 1'b1; #1;
    check("idle stall", {63'h0, stall}, 64'h0);
    start = 1'b0; mf_req = 1'b0;
    tick();

    run_op("mul 7x6", 1'b0, 1'b0, 32'd7, 32'd6, 32'h0, 32'd42, 33);
    run_op("mul full", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33);
    run_op("divu 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("divu by 0", 1'b1, 1'b0, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 33);
    run_op("divu max/1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 33);
    run_op("divu big", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33);

`ifdef MULDIV_SIGNED_EN
    run_op("div -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_op("mult -3x5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34);
    run_op("div ovf", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34);
    run_op("div -5/0", 1'b1, 1'b1, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 33);
`else
    // op_signed has no effect: 0xFFFFFFFD * 5 as unsigned
    run_op("mult sgn ignored", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'h4, 32'hFFFFFFF1, 33);
`endif

    // Hazard: MFHI from cycle 2, stray start in cycle 5
    start = 1'b1; op_div = 1'b0; op_signed = 1'b0; a = 32'd7; b = 32'd6;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      mf_req = (c >= 2);
      start  = (c == 5);
      if (c == 5) begin a = 32'd3; b = 32'd3; end
      #1;
      check($sformatf("hazard stall c%0d", c), {63'h0, stall},
            {63'h0, (c >= 2 && c <= lat)});
      if (c == lat) begin
        check("hazard done", {63'h0, done}, 64'h1);
        check("hazard lo", {hi, lo}, 64'd42);
      end
      if (c == lat + 1) check("hazard idle", {63'h0, busy}, 64'h0);
      start = 1'b0;
      tick();
    end
    mf_req = 1'b0;

    // Reset mid-multiply in cycle 10
    start = 1'b1; op_div = 1'b0; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst busy", {63'h0, busy}, 64'h0);
    check("rst hi/lo", {hi, lo}, 64'h0);
    saw_done = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      if (done || we_hilo) saw_done = 1'b1;
      tick();
      cyc++;
    end
    check("rst no done", {63'h0, saw_done}, 64'h0);
    run_op("post-rst divu", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
